aes_key_schedule: RTL and testbench
===================================

# aes_key_schedule

Word-serial AES key-expansion engine supporting AES-128, AES-192 and AES-256, selected per run. It expands the cipher key to 32-bit words, one word per cycle. It emits the Nr+1 128-bit round keys in order over a valid/ready stream. It sits between the key register and the round datapath, or the round-key store, of the AES core.

## Interface
- MAX_KEY_BITS, 256: largest supported key (128, 192 or 256); sets the width of `key`. A start requesting a longer key is rejected.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- key_len  in  2  0 = 128-bit, 1 = 192-bit, 2 = 256-bit; 3 is invalid.
- key  in  MAX_KEY_BITS  cipher key, left-aligned (word 0 in the MSBs); unused LSBs are ignored.
- busy  out  1  high from accepted start until done.
- rk  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- rk_index  out  4  round number r of `rk`.
- rk_valid  out  1  `rk`/`rk_index` valid; held until rk_ready.
- rk_ready  in  1  consumer accepts on rk_valid && rk_ready.
- done  out  1  one-cycle pulse after the last round key is accepted.
- start_err  out  1  one-cycle pulse when a start is rejected.

## Operation
- Mode constants: Nk = 4/6/8 and Nr = 10/12/14. The total word count is 4*(Nr+1), giving 44, 52 or 60 words.
- FSM states:
  - IDLE → RUN on start with a legal key_len ≤ MAX_KEY_BITS. Key and mode are latched on this edge; j=0, rcon=0x01.
  - RUN → DRAIN after the last word is computed.
  - DRAIN → IDLE on acceptance of the last round key. done pulses in the cycle after that acceptance.
- Start rejection: an illegal start (key_len=3 or too long) leaves the block in IDLE and pulses start_err.
- start while busy is ignored, with no error.
- Window: an 8×32 shift register holding the last Nk words. Each RUN cycle computes word j and shifts it in:
  - j < Nk: key word j.
  - j ≥ Nk: w[j] = w[j−Nk] ^ f(w[j−1]).
    - f = SubWord(RotWord(x)) ^ {rcon, 24'h0} when j mod Nk = 0.
    - f = SubWord(x) when Nk = 8 and j mod Nk = 4.
    - Otherwise f is the identity.
- j mod Nk is tracked by a wrapping phase counter (0..Nk−1), not a divider.
- rcon is updated after each use with xtime: 01, 02, 04, …, 80, 1B, 36.
- Words accumulate into a 4-word group. When the 4th word of a group is computed, the group loads rk/rk_index and rk_valid is set.
- Backpressure: if rk_valid && !rk_ready at the point a new group would complete, RUN stalls. The stall holds j, phase, rcon and the window. No round key is ever dropped or overwritten.
- Reset (at any time, including mid-run): state=IDLE and all counters cleared. busy, rk_valid, done and start_err = 0; rk = 0; rk_index = 0.

## Timing
- Start is accepted at edge E. Word j is computed at edge E+1+j when there is no stall.
- rk_valid for round 0 rises after edge E+4. Each subsequent round key is ready 4 cycles after the previous one.
- Unstalled run from start to the last rk_valid: 44, 52 or 60 cycles.
- With rk_ready tied high, every round key is valid for exactly 1 cycle.
- busy rises the cycle after E and falls in the same cycle done pulses.
- Acceptance of round k and completion of group k+1 on the same edge: the new group loads and rk_valid stays high, with no bubble.
- The S-box path is combinational within one cycle: window → RotWord → 4 S-boxes → XOR → window.

## Structure
- Shared AES package holds:
  - key_len encodings.
  - Nk/Nr lookup functions.
  - xtime function.
  - State enum {IDLE, RUN, DRAIN}.
- One sub-module: aes_subword, wrapping four S-box lookups (32-bit in, 32-bit out).

## Test plan
- AES-128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1 → 11 keys. rk[0] equals the key; rk[10] = d014f9a8 c9ee2589 e13f0cc8 b6630ca6; done 1 cycle after the last key; 44-cycle run.
- AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b → 13 keys; rk[12] = e98ba06f 448c773c 8ecc7204 01002202.
- AES-256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 → 15 keys; rk[14] = fe4890d1 e6188d0b 046df344 706c631e.
- Random rk_ready throttling (≈30% duty) on AES-256 → identical key sequence; rk/rk_index stable while valid && !ready; no loss or duplication.
- Error and ignore cases:
  - key_len=3 → start_err pulse, busy stays 0.
  - MAX_KEY_BITS=128 with key_len=2 → start_err.
  - start while busy → ignored, sequence unchanged.
- rst low during round 5 of AES-192 → all outputs 0 immediately. A following AES-128 start produces the correct full sequence.

Source files
------------

// File: rtl/aes_key_schedule_pkg.sv
// Shared AES definitions for the key-expansion engine: key length encodings,
// FSM states, round constants, S-box table and small mode lookup helpers.
package aes_key_schedule_pkg;

    typedef enum logic [1:0] {
        KEY_128 = 2'd0,
        KEY_192 = 2'd1,
        KEY_256 = 2'd2,
        KEY_BAD = 2'd3
    } key_len_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [3:0] nk_of(input key_len_t mode);
        case (mode)
            KEY_192: return 4'd6;
            KEY_256: return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_len_t mode);
        case (mode)
            KEY_192: return 4'd12;
            KEY_256: return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    // Total expanded words, 4*(Nr+1)
    function automatic logic [5:0] words_of(input key_len_t mode);
        return {nr_of(mode) + 4'd1, 2'b00};
    endfunction

    function automatic int key_bits_of(input key_len_t mode);
        case (mode)
            KEY_128: return 128;
            KEY_192: return 192;
            KEY_256: return 256;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// AES SubWord: four parallel S-box byte substitutions on a 32-bit word.
module aes_subword
    import aes_key_schedule_pkg::*;
(
    input  logic [31:0] data,
    output logic [31:0] sub
);

    assign sub = {SBOX[data[31:24]], SBOX[data[23:16]], SBOX[data[15:8]], SBOX[data[7:0]]};

endmodule

// File: rtl/aes_key_schedule.sv
// Word-serial AES-128/192/256 key expansion; one word per cycle, round keys
// delivered over a valid/ready stream with stall-on-backpressure.
module aes_key_schedule
    import aes_key_schedule_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              key_len,
    input  logic [MAX_KEY_BITS-1:0] key,
    output logic                    busy,
    output logic [127:0]            rk,
    output logic [3:0]              rk_index,
    output logic                    rk_valid,
    input  logic                    rk_ready,
    output logic                    done,
    output logic                    start_err
);

    state_t        state;
    key_len_t      mode;
    logic [31:0]   key_words [8];
    logic [31:0]   win [8];
    logic [5:0]    j;
    logic [2:0]    phase;
    logic [7:0]    rcon;

    logic [255:0]  key_ext;
    key_len_t      start_mode;
    logic          start_legal;
    logic [3:0]    nk;
    logic [5:0]    last_j;
    logic [31:0]   prev;
    logic [31:0]   back;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;
    logic [31:0]   f;
    logic [31:0]   new_word;
    logic          group_done;
    logic          stall;

    // Left-align the key into a 256-bit view so word i always sits at the same place
    assign key_ext     = 256'(key) << (256 - MAX_KEY_BITS);
    assign start_mode  = key_len_t'(key_len);
    assign start_legal = (start_mode != KEY_BAD) && (key_bits_of(start_mode) <= MAX_KEY_BITS);

    assign nk     = nk_of(mode);
    assign last_j = words_of(mode) - 6'd1;
    assign prev   = win[0];
    assign back   = win[3'(nk - 4'd1)];
    assign sub_in = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    aes_subword u_subword (
        .data (sub_in),
        .sub  (sub_out)
    );

    always_comb begin
        f = prev;
        if (phase == 3'd0) begin
            f = sub_out ^ {rcon, 24'h000000};
        end else if (nk == 4'd8 && phase == 3'd4) begin
            f = sub_out;
        end
    end

    assign new_word   = (j < {2'b00, nk}) ? key_words[phase] : (back ^ f);
    assign group_done = (j[1:0] == 2'b11);
    assign stall      = group_done && rk_valid && !rk_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mode      <= KEY_128;
            j         <= '0;
            phase     <= '0;
            rcon      <= '0;
            busy      <= 1'b0;
            rk        <= '0;
            rk_index  <= '0;
            rk_valid  <= 1'b0;
            done      <= 1'b0;
            start_err <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                key_words[i] <= '0;
                win[i]       <= '0;
            end
        end else begin
            start_err <= 1'b0;
            done      <= 1'b0;
            if (rk_valid && rk_ready) begin
                rk_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_legal) begin
                            state <= RUN;
                            mode  <= start_mode;
                            j     <= '0;
                            phase <= '0;
                            rcon  <= RCON_INIT;
                            busy  <= 1'b1;
                            for (int i = 0; i < 8; i++) begin
                                key_words[i] <= key_ext[255 - 32*i -: 32];
                            end
                        end else begin
                            start_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // A completed group may only load once the previous key has been taken
                    if (!stall) begin
                        for (int i = 7; i > 0; i--) begin
                            win[i] <= win[i-1];
                        end
                        win[0] <= new_word;
                        j      <= j + 6'd1;
                        phase  <= ({1'b0, phase} == nk - 4'd1) ? 3'd0 : phase + 3'd1;
                        if (j >= {2'b00, nk} && phase == 3'd0) begin
                            rcon <= xtime(rcon);
                        end
                        if (group_done) begin
                            rk       <= {win[2], win[1], win[0], new_word};
                            rk_index <= j[5:2];
                            rk_valid <= 1'b1;
                        end
                        if (j == last_j) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (rk_valid && rk_ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: known-answer round keys for all three
// key sizes, throttled output, rejected/ignored starts and mid-run reset.
module tb_aes_key_schedule;

    typedef struct {
        logic [1:0]   key_len;
        int           round;
        logic [127:0] rk;
    } vec_t;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdeffedcba9876543210};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic [1:0]    key_len;
    logic [255:0]  key;
    logic          busy;
    logic [127:0]  rk;
    logic [3:0]    rk_index;
    logic          rk_valid;
    logic          rk_ready;
    logic          done;
    logic          start_err;

    logic          start_s;
    logic [1:0]    key_len_s;
    logic [127:0]  key_s;
    logic          busy_s;
    logic [127:0]  rk_s;
    logic [3:0]    rk_index_s;
    logic          rk_valid_s;
    logic          rk_ready_s;
    logic          done_s;
    logic          start_err_s;

    aes_key_schedule #(.MAX_KEY_BITS(256)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_len   (key_len),
        .key       (key),
        .busy      (busy),
        .rk        (rk),
        .rk_index  (rk_index),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .done      (done),
        .start_err (start_err)
    );

    // Narrow instance exercises rejection of keys longer than the build supports
    aes_key_schedule #(.MAX_KEY_BITS(128)) u_dut128 (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s),
        .key_len   (key_len_s),
        .key       (key_s),
        .busy      (busy_s),
        .rk        (rk_s),
        .rk_index  (rk_index_s),
        .rk_valid  (rk_valid_s),
        .rk_ready  (rk_ready_s),
        .done      (done_s),
        .start_err (start_err_s)
    );

    int           total = 0;
    int           bad = 0;
    vec_t         vecs [$];
    logic [127:0] got_rk [16];
    logic [3:0]   got_idx [16];
    int           got_n;
    int           first_valid_cyc;
    int           last_valid_cyc;
    int           done_cyc;
    int           last_accept_cyc;
    int           valid_cycles;
    int           unstable;
    int           err_seen;
    logic         busy_at_start;
    logic         busy_at_done;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one expansion with rk_ready high ready_pct% of cycles; optional stray start mid-run
    task automatic applyStimulus(input logic [1:0] kl, input logic [255:0] k, input int nr,
                                 input int ready_pct, input int restart_cyc);
        int           cyc;
        logic         ready_now;
        logic         held;
        logic [127:0] held_rk;
        logic [3:0]   held_idx;
        got_n = 0; first_valid_cyc = -1; last_valid_cyc = -1; done_cyc = -1;
        last_accept_cyc = -1; valid_cycles = 0; unstable = 0; err_seen = 0;
        busy_at_done = 1'b1; held = 1'b0; held_rk = '0; held_idx = '0;
        @(negedge clk);
        key_len = kl; key = k; start = 1'b1; rk_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        busy_at_start = busy;
        cyc = 0;
        while (done_cyc < 0 && cyc < 400) begin
            if (held && (!rk_valid || rk !== held_rk || rk_index !== held_idx)) unstable++;
            if (start_err) err_seen++;
            if (done) begin
                done_cyc = cyc;
                busy_at_done = busy;
            end
            if (rk_valid) begin
                valid_cycles++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (rk_index == 4'(nr) && last_valid_cyc < 0) last_valid_cyc = cyc;
            end
            ready_now = ($urandom_range(99) < ready_pct);
            rk_ready = ready_now;
            if (rk_valid && ready_now) begin
                if (got_n < 16) begin
                    got_rk[got_n]  = rk;
                    got_idx[got_n] = rk_index;
                end
                got_n++;
                last_accept_cyc = cyc;
            end
            held = rk_valid && !ready_now;
            held_rk = rk;
            held_idx = rk_index;
            if (cyc == restart_cyc) begin
                start = 1'b1; key_len = 2'd2; key = ~k;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        rk_ready = 1'b0;
        start = 1'b0;
        checkOutput("done reached", 128'(done_cyc >= 0), 128'd1);
    endtask

    task automatic checkTable(input logic [1:0] kl, input string tag, input int nr);
        foreach (vecs[i]) begin
            if (vecs[i].key_len == kl) begin
                checkOutput($sformatf("%s rk[%0d]", tag, vecs[i].round), got_rk[vecs[i].round], vecs[i].rk);
            end
        end
        checkOutput({tag, " key count"}, 128'(got_n), 128'(nr + 1));
        for (int i = 0; i < got_n && i < 16; i++) begin
            checkOutput($sformatf("%s order %0d", tag, i), 128'(got_idx[i]), 128'(i));
        end
        checkOutput({tag, " busy after start"}, 128'(busy_at_start), 128'd1);
        checkOutput({tag, " done after last accept"}, 128'(done_cyc), 128'(last_accept_cyc + 1));
        checkOutput({tag, " busy low with done"}, 128'(busy_at_done), 128'd0);
    endtask

    task automatic checkUnthrottled(input string tag, input int nr);
        checkOutput({tag, " first valid cycle"}, 128'(first_valid_cyc), 128'd4);
        checkOutput({tag, " last valid cycle"}, 128'(last_valid_cyc), 128'(4 * (nr + 1)));
        checkOutput({tag, " one cycle per key"}, 128'(valid_cycles), 128'(nr + 1));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " busy"}, 128'(busy), 128'd0);
        checkOutput({tag, " rk_valid"}, 128'(rk_valid), 128'd0);
        checkOutput({tag, " done"}, 128'(done), 128'd0);
        checkOutput({tag, " start_err"}, 128'(start_err), 128'd0);
        checkOutput({tag, " rk"}, rk, 128'd0);
        checkOutput({tag, " rk_index"}, 128'(rk_index), 128'd0);
    endtask

    initial begin
        int cnt;
        vecs.push_back(vec_t'{2'd0,  0, 128'h2b7e151628aed2a6abf7158809cf4f3c});
        vecs.push_back(vec_t'{2'd0,  1, 128'ha0fafe1788542cb123a339392a6c7605});
        vecs.push_back(vec_t'{2'd0,  2, 128'hf2c295f27a96b9435935807a7359f67f});
        vecs.push_back(vec_t'{2'd0,  3, 128'h3d80477d4716fe3e1e237e446d7a883b});
        vecs.push_back(vec_t'{2'd0,  4, 128'hef44a541a8525b7fb671253bdb0bad00});
        vecs.push_back(vec_t'{2'd0,  5, 128'hd4d1c6f87c839d87caf2b8bc11f915bc});
        vecs.push_back(vec_t'{2'd0,  6, 128'h6d88a37a110b3efddbf98641ca0093fd});
        vecs.push_back(vec_t'{2'd0,  7, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f});
        vecs.push_back(vec_t'{2'd0,  8, 128'head27321b58dbad2312bf5607f8d292f});
        vecs.push_back(vec_t'{2'd0,  9, 128'hac7766f319fadc2128d12941575c006e});
        vecs.push_back(vec_t'{2'd0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
        vecs.push_back(vec_t'{2'd1,  0, 128'h8e73b0f7da0e6452c810f32b809079e5});
        vecs.push_back(vec_t'{2'd1,  1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5});
        vecs.push_back(vec_t'{2'd1, 12, 128'he98ba06f448c773c8ecc720401002202});
        vecs.push_back(vec_t'{2'd2,  0, 128'h603deb1015ca71be2b73aef0857d7781});
        vecs.push_back(vec_t'{2'd2,  1, 128'h1f352c073b6108d72d9810a30914dff4});
        vecs.push_back(vec_t'{2'd2,  2, 128'h9ba354118e6925afa51a8b5f2067fcde});
        vecs.push_back(vec_t'{2'd2, 14, 128'hfe4890d1e6188d0b046df344706c631e});

        rst = 1'b0; start = 1'b0; key_len = 2'd0; key = '0; rk_ready = 1'b0;
        start_s = 1'b0; key_len_s = 2'd0; key_s = '0; rk_ready_s = 1'b1;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b1;

        $display("[TB] AES-128, ready high");
        applyStimulus(2'd0, K128, 10, 100, -1);
        checkTable(2'd0, "aes128", 10);
        checkUnthrottled("aes128", 10);

        $display("[TB] AES-192, ready high");
        applyStimulus(2'd1, K192, 12, 100, -1);
        checkTable(2'd1, "aes192", 12);
        checkUnthrottled("aes192", 12);

        $display("[TB] AES-256, ready high");
        applyStimulus(2'd2, K256, 14, 100, -1);
        checkTable(2'd2, "aes256", 14);
        checkUnthrottled("aes256", 14);

        $display("[TB] AES-256, throttled ready");
        applyStimulus(2'd2, K256, 14, 30, -1);
        checkTable(2'd2, "aes256 thr", 14);
        checkOutput("aes256 thr held stable", 128'(unstable), 128'd0);

        $display("[TB] start while busy");
        applyStimulus(2'd0, K128, 10, 100, 10);
        checkTable(2'd0, "busy start", 10);
        checkOutput("busy start no err", 128'(err_seen), 128'd0);

        $display("[TB] illegal key_len");
        @(negedge clk);
        start = 1'b1; key_len = 2'd3; key = K256;
        @(negedge clk);
        start = 1'b0;
        checkOutput("len3 start_err", 128'(start_err), 128'd1);
        checkOutput("len3 busy", 128'(busy), 128'd0);
        @(negedge clk);
        checkOutput("len3 start_err pulse", 128'(start_err), 128'd0);
        checkOutput("len3 stays idle", 128'(busy), 128'd0);

        $display("[TB] narrow build rejects long key");
        start_s = 1'b1; key_len_s = 2'd2; key_s = K128[255:128];
        @(negedge clk);
        start_s = 1'b0;
        checkOutput("max128 len2 start_err", 128'(start_err_s), 128'd1);
        checkOutput("max128 len2 busy", 128'(busy_s), 128'd0);
        start_s = 1'b1; key_len_s = 2'd0;
        @(negedge clk);
        start_s = 1'b0;
        checkOutput("max128 len0 accepted", 128'(busy_s), 128'd1);
        checkOutput("max128 len0 no err", 128'(start_err_s), 128'd0);
        repeat (4) @(negedge clk);
        checkOutput("max128 rk0 valid", 128'(rk_valid_s), 128'd1);
        checkOutput("max128 rk0", rk_s, K128[255:128]);
        cnt = 0;
        while (!done_s && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("max128 done", 128'(done_s), 128'd1);

        $display("[TB] reset during AES-192 round 5");
        @(negedge clk);
        start = 1'b1; key_len = 2'd1; key = K192; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!(rk_valid && rk_index == 4'd5) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("reach round 5", 128'(cnt < 200), 128'd1);
        #1 rst = 1'b0;
        #1;
        checkResetOutputs("midrun reset");
        rk_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(2'd0, K128, 10, 100, -1);
        checkTable(2'd0, "after reset", 10);
        checkUnthrottled("after reset", 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
